// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Serialises one load or store request at a time onto a single-port data
//   memory with registered read data. Doubleword stores go straight to a
//   write cycle. Loads read, capture and return the selected lane. Sub-word
//   stores do a read-modify-write through a merge buffer. Illegal requests
//   are answered with a fault pulse and never touch the memory.
//
// Configuration:
//   LSU_BYTE_LANES_EN - when defined, byte/half/word accesses are supported
//                       (lane select, sign extension, store merge). When not
//                       defined, only doubleword accesses are legal and any
//                       other size is answered with a fault.
//
// Ports:
//   clk             in   sole clock, rising edge
//   rst             in   asynchronous active-low reset
//   req_valid       in   request present
//   req_ready       out  unit idle, can accept a request
//   req_load        in   load request
//   req_store       in   store request
//   req_addr        in   64-bit byte address
//   req_size        in   00 byte, 01 half, 10 word, 11 doubleword
//   req_signed      in   sign-extend load result
//   req_wdata       in   store data, right-aligned
//   resp_valid      out  one-cycle completion pulse
//   resp_data       out  load result (0 for stores and faults)
//   resp_fault      out  request rejected without memory access
//   mem_Address     out  data-memory word index
//   mem_WriteData   out  data-memory write data
//   mem_WriteEnable out  data-memory write strobe
//   mem_ReadEnable  out  data-memory read strobe
//   mem_ReadData    in   registered read data, valid the cycle after the read
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int BITSIZE = 64,
    parameter int MEMSIZE = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_load,
    input  logic                       req_store,
    input  logic [63:0]                req_addr,
    input  logic [1:0]                 req_size,
    input  logic                       req_signed,
    input  logic [BITSIZE-1:0]         req_wdata,
    output logic                       resp_valid,
    output logic [BITSIZE-1:0]         resp_data,
    output logic                       resp_fault,
    output logic [$clog2(MEMSIZE)-1:0] mem_Address,
    output logic [BITSIZE-1:0]         mem_WriteData,
    output logic                       mem_WriteEnable,
    output logic                       mem_ReadEnable,
    input  logic [BITSIZE-1:0]         mem_ReadData
);

    localparam int AW = $clog2(MEMSIZE);
    localparam logic [63:0]   LP_ADDR_LIMIT = 64'(MEMSIZE) << 3;
    // The last word of memory is reserved and may never be accessed.
    localparam logic [AW-1:0] LP_RSV_IDX    = AW'(MEMSIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CAPT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_idx;
    logic                 r_store;
    // Holds store data at acceptance; for sub-word stores it is overwritten
    // with the merged word in CAPT.
    logic [BITSIZE-1:0]   r_wbuf;
    logic                 r_resp_valid;
    logic                 r_resp_fault;
    logic [BITSIZE-1:0]   r_resp_data;

    logic [AW-1:0]        w_idx;
    logic                 w_misalign;
    logic                 w_oob;
    logic                 w_rsv;
    logic                 w_size_bad;
    logic                 w_fault;
    logic                 w_direct_write;

`ifdef LSU_BYTE_LANES_EN
    logic [2:0]           r_off;
    logic [1:0]           r_size;
    logic                 r_signed;

    // Right-aligned all-ones mask covering the access size.
    function automatic logic [BITSIZE-1:0] f_size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   f_size_mask = {{(BITSIZE-8){1'b0}},  8'hFF};
            2'b01:   f_size_mask = {{(BITSIZE-16){1'b0}}, 16'hFFFF};
            2'b10:   f_size_mask = {{(BITSIZE-32){1'b0}}, 32'hFFFF_FFFF};
            default: f_size_mask = {BITSIZE{1'b1}};
        endcase
    endfunction

    // Pick the addressed lane out of a memory word and extend it.
    function automatic logic [BITSIZE-1:0] f_extract(
        input logic [BITSIZE-1:0] d,
        input logic [2:0]         off,
        input logic [1:0]         sz,
        input logic               sgn
    );
        logic [BITSIZE-1:0] sh;
        logic [BITSIZE-1:0] m;
        logic               msb;
        sh = d >> {off, 3'b000};
        m  = f_size_mask(sz);
        case (sz)
            2'b00:   msb = sh[7];
            2'b01:   msb = sh[15];
            2'b10:   msb = sh[31];
            default: msb = 1'b0;
        endcase
        f_extract = (sgn && msb) ? ((sh & m) | ~m) : (sh & m);
    endfunction

    // Replace the addressed lane of a memory word with the low store bits.
    function automatic logic [BITSIZE-1:0] f_merge(
        input logic [BITSIZE-1:0] d,
        input logic [BITSIZE-1:0] w,
        input logic [2:0]         off,
        input logic [1:0]         sz
    );
        logic [BITSIZE-1:0] m;
        m       = f_size_mask(sz) << {off, 3'b000};
        f_merge = (d & ~m) | ((w << {off, 3'b000}) & m);
    endfunction

    assign w_size_bad     = 1'b0;
    assign w_direct_write = req_store && (req_size == 2'b11);
`else
    // Sign selection only matters for sub-word loads.
    logic w_unused;
    assign w_unused       = req_signed;
    assign w_size_bad     = (req_size != 2'b11);
    assign w_direct_write = req_store;
`endif

    assign w_idx = req_addr[AW+2:3];
    assign w_oob = (req_addr >= LP_ADDR_LIMIT);
    assign w_rsv = (w_idx == LP_RSV_IDX);

    // Natural alignment check for the requested size.
    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            2'b11:   w_misalign = |req_addr[2:0];
            default: w_misalign = 1'b1;
        endcase
    end

    // A request needs exactly one of load/store to be legal.
    assign w_fault = (req_load == req_store) | w_misalign | w_oob | w_rsv | w_size_bad;

    // Request sequencing, field latching and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_store      <= 1'b0;
            r_wbuf       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= '0;
`ifdef LSU_BYTE_LANES_EN
            r_off        <= 3'd0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_idx    <= w_idx;
                        r_store  <= req_store;
                        r_wbuf   <= req_wdata;
`ifdef LSU_BYTE_LANES_EN
                        r_off    <= req_addr[2:0];
                        r_size   <= req_size;
                        r_signed <= req_signed;
`endif
                        // Faults are answered straight from IDLE.
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_state      <= S_IDLE;
                        end else if (w_direct_write) begin
                            r_state      <= S_WRITE;
                        end else begin
                            r_state      <= S_READ;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    if (r_store) begin
`ifdef LSU_BYTE_LANES_EN
                        r_wbuf  <= f_merge(mem_ReadData, r_wbuf, r_off, r_size);
`endif
                        r_state <= S_WRITE;
                    end else begin
`ifdef LSU_BYTE_LANES_EN
                        r_resp_data <= f_extract(mem_ReadData, r_off, r_size, r_signed);
`else
                        r_resp_data <= mem_ReadData;
`endif
                        r_resp_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and address decode from the state register so that reset
    // removes them immediately.
    assign req_ready       = (r_state == S_IDLE);
    assign mem_ReadEnable  = (r_state == S_READ);
    assign mem_WriteEnable = (r_state == S_WRITE);
    assign mem_Address     = (r_state == S_IDLE) ? '0 : r_idx;
    assign mem_WriteData   = r_wbuf;

    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives load_store_unit against a registered-read memory model. Expected
// results come from a byte-level reference memory and the access rules.
// Works in both builds: with LSU_BYTE_LANES_EN undefined, sub-word requests
// are expected to fault.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int BITSIZE = 64;
    localparam int MEMSIZE = 64;
    localparam int AW      = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_load;
    logic               req_store;
    logic [63:0]        req_addr;
    logic [1:0]         req_size;
    logic               req_signed;
    logic [BITSIZE-1:0] req_wdata;
    logic               resp_valid;
    logic [BITSIZE-1:0] resp_data;
    logic               resp_fault;
    logic [AW-1:0]      mem_Address;
    logic [BITSIZE-1:0] mem_WriteData;
    logic               mem_WriteEnable;
    logic               mem_ReadEnable;
    logic [BITSIZE-1:0] mem_ReadData = '0;

    logic [63:0] mem     [0:MEMSIZE-1] = '{default: 64'd0};
    logic [63:0] ref_mem [0:MEMSIZE-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.BITSIZE(BITSIZE), .MEMSIZE(MEMSIZE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
        .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
        .mem_WriteEnable(mem_WriteEnable), .mem_ReadEnable(mem_ReadEnable),
        .mem_ReadData(mem_ReadData)
    );

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_WriteEnable) mem[mem_Address] <= mem_WriteData;
        if (mem_ReadEnable)  mem_ReadData     <= mem[mem_Address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Issue one request (starting just after a falling edge) and check the
    // complete transaction against the reference model.
    task automatic do_req(input logic ld, input logic st, input logic [63:0] addr,
                          input logic [1:0] sz, input logic sg, input logic [63:0] wd);
        int          nb, off, idx, exp_lat, exp_re, exp_we, k, re_n, we_n, w;
        logic        exp_fault, seen, addr_bad, wd_bad, both_hi;
        logic [63:0] word, val, exp_data;

        nb  = 1 << sz;
        off = int'(addr % 64'd8);
        idx = int'((addr >> 3) % 64'(MEMSIZE));
        exp_fault = (ld == st) || ((addr % 64'(nb)) != 64'd0) ||
                    (addr >= 64'(MEMSIZE * 8)) || ((addr >> 3) == 64'(MEMSIZE - 1));
`ifndef LSU_BYTE_LANES_EN
        exp_fault = exp_fault || (nb != 8);
`endif
        word = ref_mem[idx];
        exp_data = 64'd0;
        exp_re = 0; exp_we = 0; exp_lat = 1;
        if (exp_fault) begin
            exp_lat = 1;
        end else if (ld) begin
            val = 64'd0;
            for (int b = 0; b < nb; b++) val[8*b +: 8] = word[8*(off+b) +: 8];
            if (sg && nb < 8 && val[8*nb-1])
                for (int b = nb; b < 8; b++) val[8*b +: 8] = 8'hFF;
            exp_data = val;
            exp_lat = 3; exp_re = 1;
        end else begin
            for (int b = 0; b < nb; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
            exp_lat = (nb == 8) ? 2 : 4;
            exp_re  = (nb == 8) ? 0 : 1;
            exp_we  = 1;
        end

        w = 0;
        while (req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", 64'(req_ready), 64'd1);

        req_valid = 1'b1; req_load = ld; req_store = st; req_addr = addr;
        req_size = sz; req_signed = sg; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;

        k = 0; seen = 1'b0; re_n = 0; we_n = 0;
        addr_bad = 1'b0; wd_bad = 1'b0; both_hi = 1'b0;
        while (!seen && k < 8) begin
            @(negedge clk);
            k++;
            if (mem_ReadEnable && mem_WriteEnable) both_hi = 1'b1;
            if (mem_ReadEnable) begin
                re_n++;
                if (int'(mem_Address) != idx) addr_bad = 1'b1;
            end
            if (mem_WriteEnable) begin
                we_n++;
                if (int'(mem_Address) != idx) addr_bad = 1'b1;
                if (mem_WriteData !== word) wd_bad = 1'b1;
            end
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        chk("resp_latency", 64'(k), 64'(exp_lat));
        chk("resp_fault", 64'(resp_fault), 64'(exp_fault));
        chk("resp_data", resp_data, exp_data);
        chk("read_strobes", 64'(re_n), 64'(exp_re));
        chk("write_strobes", 64'(we_n), 64'(exp_we));
        chk("strobe_address", 64'(addr_bad), 64'd0);
        chk("write_data", 64'(wd_bad), 64'd0);
        chk("strobes_overlap", 64'(both_hi), 64'd0);
        chk("ready_at_resp", 64'(req_ready), 64'd1);
        chk("idle_address", 64'(mem_Address), 64'd0);
        if (!exp_fault && st) ref_mem[idx] = word;
    endtask

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "time limit reached");
    end

    initial begin
        int          w, resp_n;
        logic        ld, st, sg;
        logic [1:0]  sz;
        logic [63:0] addr;
        int          r, nb;

        for (int i = 0; i < MEMSIZE; i++) ref_mem[i] = 64'd0;
        rst = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_addr = 64'd0; req_size = 2'd0; req_signed = 1'b0; req_wdata = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_fault", 64'(resp_fault), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_strobes", 64'({mem_ReadEnable, mem_WriteEnable}), 64'd0);
        chk("rst_address", 64'(mem_Address), 64'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // Doubleword store then load.
        do_req(1'b0, 1'b1, 64'h10, 2'b11, 1'b0, 64'hDEADBEEF_01234567);
        do_req(1'b1, 1'b0, 64'h10, 2'b11, 1'b0, 64'd0);
        // Byte store over that word, signed/unsigned byte loads, word reload.
        do_req(1'b0, 1'b1, 64'h13, 2'b00, 1'b0, 64'h80);
        do_req(1'b1, 1'b0, 64'h13, 2'b00, 1'b1, 64'd0);
        do_req(1'b1, 1'b0, 64'h13, 2'b00, 1'b0, 64'd0);
        do_req(1'b1, 1'b0, 64'h10, 2'b11, 1'b0, 64'd0);
        // Faults: misaligned, reserved word, out of range, both/neither op.
        do_req(1'b1, 1'b0, 64'h11, 2'b01, 1'b0, 64'd0);
        do_req(1'b1, 1'b0, 64'h1F8, 2'b11, 1'b0, 64'd0);
        do_req(1'b1, 1'b0, 64'h200, 2'b11, 1'b0, 64'd0);
        do_req(1'b1, 1'b1, 64'h10, 2'b11, 1'b0, 64'd0);
        do_req(1'b0, 1'b0, 64'h10, 2'b11, 1'b0, 64'd0);
        // Word store to 0x8 then doubleword readback.
        do_req(1'b0, 1'b1, 64'h8, 2'b10, 1'b0, 64'h11223344_55667788);
        do_req(1'b1, 1'b0, 64'h8, 2'b11, 1'b0, 64'd0);
        do_req(1'b1, 1'b0, 64'h8, 2'b10, 1'b1, 64'd0);

        // Reset while a store is in its write cycle.
`ifdef LSU_BYTE_LANES_EN
        sz = 2'b00;
`else
        sz = 2'b11;
`endif
        req_valid = 1'b1; req_store = 1'b1; req_load = 1'b0; req_addr = 64'h30;
        req_size = sz; req_signed = 1'b0; req_wdata = 64'hA5A5A5A5_A5A5A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'b0;
        w = 0;
        while (mem_WriteEnable !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("reached_write", 64'(mem_WriteEnable), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_drops_write", 64'(mem_WriteEnable), 64'd0);
        chk("rst_drops_read", 64'(mem_ReadEnable), 64'd0);
        chk("rst_no_resp", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_release", 64'(req_ready), 64'd1);
        resp_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) resp_n++;
        end
        chk("no_resp_after_abort", 64'(resp_n), 64'd0);
        do_req(1'b1, 1'b0, 64'h30, 2'b11, 1'b0, 64'd0);

        // Randomised traffic, mostly back-to-back.
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            ld = (r == 0) || (r >= 1 && r <= 4);
            st = (r == 0) || (r >= 5);
            if (r == 9) begin
                ld = 1'b0; st = 1'b0;
            end
            sz = 2'($urandom_range(0, 3));
`ifndef LSU_BYTE_LANES_EN
            if ($urandom_range(0, 1) == 0) sz = 2'b11;
`endif
            nb = 1 << sz;
            addr = 64'($urandom_range(0, 32'h207));
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nb - 1);
            sg = 1'($urandom_range(0, 1));
            do_req(ld, st, addr, sz, sg, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 2))) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
